// File: rtl/prefetcher_opcode_arbiter.sv
// prefetcher_opcode_arbiter: single-issue opcode scheduler feeding the prefetcher data queue.
// Optional: PREFETCHER_ARB_ANTISTARVE_EN lets a starved drain outrank AR requests.
`default_nettype none

module prefetcher_opcode_arbiter #(
  parameter int  LOG_QUEUE_SIZE       = 8,
  parameter int  LOG_BLOCK_DATA_BYTES = 6,
  parameter int  ADDR_BITS            = 64,
  parameter int  STARVE_LIMIT         = 4,
  localparam int BLOCK_BITS           = 8 << LOG_BLOCK_DATA_BYTES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      clr_err,
  input  logic                      s_r_valid,
  output logic                      s_r_ready,
  input  logic [BLOCK_BITS-1:0]     s_r_data,
  input  logic                      s_r_last,
  input  logic                      m_ar_valid,
  output logic                      m_ar_ready,
  input  logic [ADDR_BITS-1:0]      m_ar_addr,
  output logic                      m_r_valid,
  input  logic                      m_r_ready,
  output logic [BLOCK_BITS-1:0]     m_r_data,
  output logic                      m_r_last,
  input  logic                      pf_valid,
  output logic                      pf_ready,
  input  logic [ADDR_BITS-1:0]      pf_addr,
  input  logic [LOG_QUEUE_SIZE:0]   crs_maxPrefetch,
  output logic [2:0]                dp_reqOpcode,
  output logic [ADDR_BITS-1:0]      dp_reqAddr,
  output logic [BLOCK_BITS-1:0]     dp_reqData,
  output logic                      dp_reqLast,
  input  logic [BLOCK_BITS-1:0]     dp_respData,
  input  logic                      dp_respLast,
  input  logic                      dp_addrHit,
  input  logic                      dp_pr_r_valid,
  input  logic                      dp_almostFull,
  input  logic [LOG_QUEUE_SIZE:0]   dp_prefetchReqCnt,
  input  logic [2:0]                dp_errorCode,
  output logic [1:0]                arb_state,
  output logic [2:0]                err_code
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [2:0] c_OP_NOP   = 3'd0;
  localparam logic [2:0] c_OP_PF    = 3'd1;
  localparam logic [2:0] c_OP_AR    = 3'd2;
  localparam logic [2:0] c_OP_WR    = 3'd3;
  localparam logic [2:0] c_OP_DRAIN = 3'd4;

  state_t     r_state;
  logic       r_rd_pending;
  logic       r_drain_hold;
  logic [2:0] r_err_code;

  logic w_run;
  logic w_free;
  logic w_ar_ok;
  logic w_starved;
  logic w_drain_sel;

  assign w_run   = (r_state == ST_RUN);
  // Slave R beats own both their accept cycle and the following opcode-3 slot.
  assign w_free  = w_run & ~r_rd_pending & ~s_r_valid;
  assign w_ar_ok = m_ar_valid & (dp_addrHit | ~dp_almostFull);

  assign s_r_ready  = w_run;
  assign dp_reqData = s_r_data;
  assign dp_reqLast = s_r_last & s_r_valid;
  assign dp_reqAddr = m_ar_valid ? m_ar_addr : pf_addr;
  assign m_r_data   = dp_respData;
  assign m_r_last   = dp_respLast;
  assign arb_state  = r_state;
  assign err_code   = r_err_code;

`ifdef PREFETCHER_ARB_ANTISTARVE_EN
  logic [3:0] r_starve;

  assign w_starved = (r_starve >= 4'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if (w_drain_sel) begin
      r_starve <= 4'd0;
    end else if (w_run && dp_pr_r_valid && !w_starved) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`else
  // Without the counter a drain is never considered starved.
  assign w_starved = (STARVE_LIMIT < 0);
`endif

  always_comb begin
    m_ar_ready   = 1'b0;
    m_r_valid    = 1'b0;
    pf_ready     = 1'b0;
    w_drain_sel  = 1'b0;
    dp_reqOpcode = r_rd_pending ? c_OP_WR : c_OP_NOP;
    if (w_free) begin
      if (r_drain_hold || (dp_pr_r_valid && (w_starved || !w_ar_ok))) begin
        m_r_valid   = 1'b1;
        w_drain_sel = 1'b1;
        if (m_r_ready) begin
          dp_reqOpcode = c_OP_DRAIN;
        end
      end else if (w_ar_ok) begin
        m_ar_ready   = 1'b1;
        dp_reqOpcode = c_OP_AR;
      end else if (pf_valid && !m_ar_valid) begin
        // A hit means the block is already queued: accept and drop it.
        if (dp_addrHit) begin
          pf_ready = 1'b1;
        end else if (!dp_almostFull && (dp_prefetchReqCnt < crs_maxPrefetch)) begin
          pf_ready     = 1'b1;
          dp_reqOpcode = c_OP_PF;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_err_code   <= 3'd0;
      r_rd_pending <= 1'b0;
      r_drain_hold <= 1'b0;
    end else begin
      r_rd_pending <= s_r_valid & s_r_ready;
      if (w_drain_sel) begin
        r_drain_hold <= ~m_r_ready;
      end
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (dp_errorCode != 3'd0) begin
            r_state    <= ST_HALT;
            r_err_code <= dp_errorCode;
          end
        end
        ST_HALT: begin
          if (clr_err) begin
            r_state    <= ST_IDLE;
            r_err_code <= 3'd0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prefetcher_opcode_arbiter.sv
// tb_prefetcher_opcode_arbiter: directed bench with an opcode-3 scoreboard for prefetcher_opcode_arbiter.
`default_nettype none

module tb_prefetcher_opcode_arbiter;
  localparam int LQ = 8;
  localparam int LB = 6;
  localparam int AW = 64;
  localparam int BB = 8 << LB;

  logic          clk = 1'b0;
  logic          reset, enable, clr_err;
  logic          s_r_valid, s_r_ready, s_r_last;
  logic [BB-1:0] s_r_data;
  logic          m_ar_valid, m_ar_ready;
  logic [AW-1:0] m_ar_addr;
  logic          m_r_valid, m_r_ready, m_r_last;
  logic [BB-1:0] m_r_data;
  logic          pf_valid, pf_ready;
  logic [AW-1:0] pf_addr;
  logic [LQ:0]   crs_maxPrefetch, dp_prefetchReqCnt;
  logic [2:0]    dp_reqOpcode, dp_errorCode, err_code;
  logic [AW-1:0] dp_reqAddr;
  logic [BB-1:0] dp_reqData, dp_respData;
  logic          dp_reqLast, dp_respLast;
  logic          dp_addrHit, dp_pr_r_valid, dp_almostFull;
  logic [1:0]    arb_state;

  prefetcher_opcode_arbiter #(
    .LOG_QUEUE_SIZE(LQ), .LOG_BLOCK_DATA_BYTES(LB), .ADDR_BITS(AW), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clr_err(clr_err),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_last(s_r_last),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_last(m_r_last),
    .pf_valid(pf_valid), .pf_ready(pf_ready), .pf_addr(pf_addr),
    .crs_maxPrefetch(crs_maxPrefetch),
    .dp_reqOpcode(dp_reqOpcode), .dp_reqAddr(dp_reqAddr), .dp_reqData(dp_reqData),
    .dp_reqLast(dp_reqLast), .dp_respData(dp_respData), .dp_respLast(dp_respLast),
    .dp_addrHit(dp_addrHit), .dp_pr_r_valid(dp_pr_r_valid), .dp_almostFull(dp_almostFull),
    .dp_prefetchReqCnt(dp_prefetchReqCnt), .dp_errorCode(dp_errorCode),
    .arb_state(arb_state), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_err    = 0;
  logic [BB-1:0] sb_q[$];

  task automatic chk(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge; an accepted beat must surface as opcode 3 exactly one cycle later.
  task automatic tick(input bit accept);
    logic [BB-1:0] d;
    if (accept) sb_q.push_back(s_r_data);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      d = sb_q.pop_front();
      chk($sformatf("rd_op3_beat_%0h", d[15:0]), dp_reqOpcode, 3);
    end else begin
      chk("no_spurious_op3", dp_reqOpcode == 3'd3, 0);
    end
  endtask

  task automatic clear_inputs();
    enable = 0; clr_err = 0;
    s_r_valid = 0; s_r_data = '0; s_r_last = 0;
    m_ar_valid = 0; m_ar_addr = '0; m_r_ready = 0;
    pf_valid = 0; pf_addr = '0;
    crs_maxPrefetch = 2; dp_prefetchReqCnt = 0;
    dp_respData = '0; dp_respLast = 0;
    dp_addrHit = 0; dp_pr_r_valid = 0; dp_almostFull = 0; dp_errorCode = 0;
  endtask

  initial begin
    logic [BB-1:0] beat;
    bit            exp_drain;

    clear_inputs();
    reset = 1;
    @(negedge clk); #1;
    chk("rst_s_r_ready", s_r_ready, 0);
    chk("rst_m_ar_ready", m_ar_ready, 0);
    chk("rst_pf_ready", pf_ready, 0);
    chk("rst_m_r_valid", m_r_valid, 0);
    chk("rst_opcode", dp_reqOpcode, 0);
    chk("rst_reqData", dp_reqData, 0);
    chk("rst_reqLast", dp_reqLast, 0);
    chk("rst_state", arb_state, 0);
    chk("rst_err_code", err_code, 0);

    reset = 0; m_ar_valid = 1; m_ar_addr = 64'hA000; #1;
    chk("idle_no_ar", m_ar_ready, 0);
    m_ar_valid = 0; enable = 1;
    tick(0);
    enable = 0; #1;
    chk("enter_run", arb_state, 1);

    // Queue space: AR needs a hit when almost full.
    dp_almostFull = 1; m_ar_valid = 1; pf_addr = 64'hB000; dp_addrHit = 0; #1;
    chk("ar_full_miss_ready", m_ar_ready, 0);
    chk("ar_full_miss_op", dp_reqOpcode, 0);
    chk("addr_sel_ar", dp_reqAddr, 64'hA000);
    dp_addrHit = 1; #1;
    chk("ar_full_hit_ready", m_ar_ready, 1);
    chk("ar_full_hit_op", dp_reqOpcode, 2);
    tick(0);

    // Prefetch cap and duplicate drop.
    m_ar_valid = 0; dp_addrHit = 0; dp_almostFull = 0; pf_valid = 1;
    crs_maxPrefetch = 2; dp_prefetchReqCnt = 2; #1;
    chk("addr_sel_pf", dp_reqAddr, 64'hB000);
    chk("pf_cap_block", pf_ready, 0);
    dp_addrHit = 1; #1;
    chk("pf_dup_ready", pf_ready, 1);
    chk("pf_dup_op", dp_reqOpcode, 0);
    dp_addrHit = 0; dp_prefetchReqCnt = 1; #1;
    chk("pf_issue_ready", pf_ready, 1);
    chk("pf_issue_op", dp_reqOpcode, 1);
    crs_maxPrefetch = 0; dp_prefetchReqCnt = 0; #1;
    chk("pf_cap_zero", pf_ready, 0);
    pf_valid = 0; crs_maxPrefetch = 2;
    tick(0);

    // Three back-to-back R beats with an AR waiting throughout.
    m_ar_addr = 64'hC000;
    for (int i = 0; i < 3; i++) begin
      beat = {8{64'h5A5A_0000_0000_0000 + 64'(i + 1)}};
      s_r_valid = 1; s_r_data = beat; s_r_last = (i == 2); m_ar_valid = 1; #1;
      chk("burst_reqData", dp_reqData, beat);
      chk("burst_reqLast", dp_reqLast, (i == 2) ? 1 : 0);
      chk("burst_s_r_ready", s_r_ready, 1);
      chk("burst_ar_stall", m_ar_ready, 0);
      tick(1);
    end
    s_r_valid = 0; s_r_last = 0; s_r_data = '0; #1;
    chk("burst_tail_ar_stall", m_ar_ready, 0);
    tick(0);
    #1;
    chk("burst_ar_ready", m_ar_ready, 1);
    chk("burst_ar_op", dp_reqOpcode, 2);
    m_ar_valid = 0;
    tick(0);

    // Drain offered without ready, then held against a competing AR.
    dp_pr_r_valid = 1; m_r_ready = 0; dp_respData = {16{32'hDEAD_BEEF}}; dp_respLast = 1; #1;
    chk("drain_valid", m_r_valid, 1);
    chk("drain_data", m_r_data, {16{32'hDEAD_BEEF}});
    chk("drain_last", m_r_last, 1);
    chk("drain_wait_op", dp_reqOpcode, 0);
    tick(0);
    dp_pr_r_valid = 0; m_ar_valid = 1; #1;
    chk("hold_valid", m_r_valid, 1);
    chk("hold_blocks_ar", m_ar_ready, 0);
    m_r_ready = 1; #1;
    chk("hold_op", dp_reqOpcode, 4);
    tick(0);
    m_r_ready = 0; #1;
    chk("hold_released", m_r_valid, 0);
    chk("ar_after_hold", m_ar_ready, 1);
    m_ar_valid = 0;
    tick(0);

    // Asynchronous reset while a drain is being held.
    dp_pr_r_valid = 1; #1;
    tick(0);
    dp_pr_r_valid = 0; #1;
    chk("pre_rst_hold", m_r_valid, 1);
    reset = 1; #1;
    chk("midrst_m_r_valid", m_r_valid, 0);
    chk("midrst_state", arb_state, 0);
    chk("midrst_op", dp_reqOpcode, 0);
    tick(0);
    chk("midrst_state_next", arb_state, 0);
    reset = 0; enable = 1;
    tick(0);
    enable = 0; #1;
    chk("rerun_state", arb_state, 1);
    chk("rerun_hold_cleared", m_r_valid, 0);

    // Continuous AR against a pending drain.
    m_ar_valid = 1; dp_pr_r_valid = 1; m_r_ready = 1;
    for (int c = 1; c <= 6; c++) begin
      #1;
`ifdef PREFETCHER_ARB_ANTISTARVE_EN
      exp_drain = (c == 5);
`else
      exp_drain = 0;
`endif
      chk($sformatf("starve_c%0d_ar", c), m_ar_ready, exp_drain ? 0 : 1);
      chk($sformatf("starve_c%0d_drain", c), m_r_valid, exp_drain ? 1 : 0);
      chk($sformatf("starve_c%0d_op", c), dp_reqOpcode, exp_drain ? 4 : 2);
      tick(0);
    end
    m_ar_valid = 0; dp_pr_r_valid = 0; m_r_ready = 0;

    // Error halts; a beat accepted in the error cycle still issues opcode 3.
    s_r_valid = 1; s_r_data = {8{64'hE7}}; dp_errorCode = 2; #1;
    tick(1);
    s_r_valid = 1; m_ar_valid = 1; pf_valid = 1; dp_pr_r_valid = 1; m_r_ready = 1;
    dp_errorCode = 3; #1;
    chk("halt_state", arb_state, 2);
    chk("halt_err_code", err_code, 2);
    chk("halt_s_r_ready", s_r_ready, 0);
    chk("halt_m_ar_ready", m_ar_ready, 0);
    chk("halt_pf_ready", pf_ready, 0);
    chk("halt_m_r_valid", m_r_valid, 0);
    tick(0);
    #1;
    chk("halt_op_nop", dp_reqOpcode, 0);
    chk("halt_err_sticky", err_code, 2);
    clear_inputs();
    clr_err = 1;
    tick(0);
    clr_err = 0; #1;
    chk("clr_state", arb_state, 0);
    chk("clr_err_code", err_code, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
